// File: rtl/lfsr_4_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_4_checker_if
// Description : Serial receive port and status outputs of the 4-bit PRBS
//               checker. The master side feeds bits, the slave side checks.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_4_checker_if;
  logic       enable;
  logic       bit_in;
  logic       clr_cnt;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;

  modport master (
    output enable, bit_in, clr_cnt,
    input  locked, err_pulse, err_cnt
  );

  modport slave (
    input  enable, bit_in, clr_cnt,
    output locked, err_pulse, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_4_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_4_checker
// Description : Self-synchronising checker for the x^4+x^3+1 PRBS stream.
//               Seeds from received bits, hunts for LOCK_CNT consecutive
//               correct predictions, then flywheels the sequence and counts
//               bit errors until ERR_LIMIT consecutive misses drop lock.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_4_checker #(
  parameter int unsigned LOCK_CNT  = 8,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  lfsr_4_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    SEED = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_TGT = 4'(ERR_LIMIT);

  state_t     state;
  logic [3:0] sr;
  logic [2:0] seed_cnt;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic       lock_flag;
  logic       pulse;
  logic [7:0] err_count;

  logic       pred;
  logic       hit;
  logic [3:0] sr_rx;
  logic [3:0] sr_fly;
  logic [3:0] match_nxt;
  logic [3:0] miss_nxt;

  // Prediction from the two oldest taps and the two candidate shift values:
  // received data re-seeds the register, the prediction flywheels it.
  always_comb begin
    pred      = sr[3] ^ sr[2];
    hit       = (bus.bit_in == pred);
    sr_rx     = {sr[2:0], bus.bit_in};
    sr_fly    = {sr[2:0], pred};
    match_nxt = match_cnt + 4'd1;
    miss_nxt  = miss_cnt + 4'd1;
  end

  // Acquisition/tracking FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEED;
      sr        <= 4'd0;
      seed_cnt  <= 3'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      lock_flag <= 1'b0;
      pulse     <= 1'b0;
      err_count <= 8'd0;
    end else begin
      pulse <= 1'b0;
      if (bus.enable) begin
        case (state)
          SEED: begin
            sr <= sr_rx;
            if (seed_cnt != 3'd4) begin
              seed_cnt <= seed_cnt + 3'd1;
            end
            // The fourth seeded bit completes the register; an all-zero
            // register cannot predict anything, so keep seeding.
            if ((seed_cnt >= 3'd3) && (sr_rx != 4'd0)) begin
              state     <= HUNT;
              match_cnt <= 4'd0;
            end
          end
          HUNT: begin
            sr <= sr_rx;
            if (sr_rx == 4'd0) begin
              state     <= SEED;
              seed_cnt  <= 3'd0;
              match_cnt <= 4'd0;
            end else if (hit) begin
              match_cnt <= match_nxt;
              if (match_nxt == LOCK_TGT) begin
                state     <= LOCK;
                lock_flag <= 1'b1;
                miss_cnt  <= 4'd0;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCK: begin
            sr <= sr_fly;
            if (hit) begin
              miss_cnt <= 4'd0;
            end else begin
              pulse    <= 1'b1;
              miss_cnt <= miss_nxt;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              if (miss_nxt == MISS_TGT) begin
                state     <= SEED;
                seed_cnt  <= 3'd0;
                lock_flag <= 1'b0;
              end
            end
          end
          default: begin
            state     <= SEED;
            seed_cnt  <= 3'd0;
            lock_flag <= 1'b0;
          end
        endcase
      end
      // Clear has priority over a same-edge increment.
      if (bus.clr_cnt) begin
        err_count <= 8'd0;
      end
    end
  end

  assign bus.locked    = lock_flag;
  assign bus.err_pulse = pulse;
  assign bus.err_cnt   = err_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_4_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_4_checker
// Description : Randomised self-checking bench for lfsr_4_checker against a
//               sequence-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_4_checker;
  localparam int LOCK_CNT  = 8;
  localparam int ERR_LIMIT = 4;
  localparam int M_SEED = 0, M_HUNT = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  lfsr_4_checker_if bus();

  lfsr_4_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One full period of the generator output from seed 0001.
  bit tbl [15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
  int tx_idx = 0;

  // Reference model state
  int m_mode, m_seed_len, m_match, m_miss, m_phase, m_err;
  bit m_pulse;
  bit rx [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SEED; m_seed_len = 0; m_match = 0; m_miss = 0;
    m_phase = 0; m_err = 0; m_pulse = 0;
    rx.delete();
  endtask

  function automatic bit rx_nonzero();
    return rx[0] | rx[1] | rx[2] | rx[3];
  endfunction

  // Position in the table of the newest bit of the last four received.
  function automatic int locate();
    for (int p = 0; p < 15; p++)
      if (tbl[(p+12)%15] == rx[0] && tbl[(p+13)%15] == rx[1] &&
          tbl[(p+14)%15] == rx[2] && tbl[p] == rx[3]) return p;
    return -1;
  endfunction

  task automatic model_step(input bit en, input bit b, input bit clr);
    bit p;
    m_pulse = 0;
    if (en) begin
      case (m_mode)
        M_SEED: begin
          rx.push_back(b); if (rx.size() > 4) void'(rx.pop_front());
          m_seed_len++;
          if (m_seed_len >= 4 && rx_nonzero()) begin m_mode = M_HUNT; m_match = 0; end
        end
        M_HUNT: begin
          p = rx[0] ^ rx[1];   // s[n-4] ^ s[n-3]
          rx.push_back(b); if (rx.size() > 4) void'(rx.pop_front());
          if (!rx_nonzero()) begin
            m_mode = M_SEED; m_seed_len = 0;
          end else if (b == p) begin
            m_match++;
            if (m_match == LOCK_CNT) begin
              m_mode = M_LOCK; m_miss = 0; m_phase = locate();
            end
          end else m_match = 0;
        end
        default: begin
          rx.push_back(b); if (rx.size() > 4) void'(rx.pop_front());
          m_phase = (m_phase + 1) % 15;
          if (b != tbl[m_phase]) begin
            m_pulse = 1;
            if (m_err < 255) m_err++;
            m_miss++;
            if (m_miss == ERR_LIMIT) begin m_mode = M_SEED; m_seed_len = 0; end
          end else m_miss = 0;
        end
      endcase
    end
    if (clr) m_err = 0;
  endtask

  // One clock: drive at negedge, model on the edge, compare 1 ns later.
  task automatic cycle(input bit en, input bit b, input bit clr);
    bus.enable = en; bus.bit_in = b; bus.clr_cnt = clr;
    @(posedge clk);
    model_step(en, b, clr);
    #1;
    check_val("locked",    32'(bus.locked),    32'(m_mode == M_LOCK));
    check_val("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
    check_val("err_cnt",   32'(bus.err_cnt),   32'(m_err));
    @(negedge clk);
  endtask

  task automatic send(input bit en, input bit flip, input bit clr);
    bit b;
    if (en) begin
      b = tbl[tx_idx] ^ flip;
      tx_idx = (tx_idx + 1) % 15;
    end else b = 1'($urandom);
    cycle(en, b, clr);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset(input bit check_now);
    #2 reset_n = 1'b0;
    #1;
    if (check_now) begin
      check_val("rst_locked",    32'(bus.locked),    32'd0);
      check_val("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
      check_val("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lock_run(input string tag, input bit toggle, input int nbits);
    int lock_at = -1;
    int k = 0;
    for (int i = 0; i < nbits; i++) begin
      bit en = toggle ? (i % 2 == 0) : 1'b1;
      send(en, 1'b0, 1'b0);
      if (en) k++;
      if (bus.locked && lock_at < 0) lock_at = k;
    end
    check_val(tag, 32'(lock_at), 32'd12);
  endtask

  initial begin
    bus.enable = 0; bus.bit_in = 0; bus.clr_cnt = 0;
    model_reset();
    #1 reset_n = 1'b0;
    #10;
    check_val("reset_locked",    32'(bus.locked),    32'd0);
    check_val("reset_err_pulse", 32'(bus.err_pulse), 32'd0);
    check_val("reset_err_cnt",   32'(bus.err_cnt),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean stream from seed 0001
    tx_idx = 0;
    lock_run("lock_point", 1'b0, 60);

    // Single inverted bit while locked
    send(1'b1, 1'b1, 1'b0);
    check_val("single_err_pulse", 32'(bus.err_pulse), 32'd1);
    for (int i = 0; i < 30; i++) send(1'b1, 1'b0, 1'b0);
    check_val("single_err_cnt", 32'(bus.err_cnt), 32'd1);
    check_val("single_err_lock", 32'(bus.locked), 32'd1);

    // Stuck-at-zero input: loses lock and must not relock
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    check_val("zero_unlocked", 32'(bus.locked), 32'd0);

    // Enable toggling every cycle
    async_reset(1'b0);
    tx_idx = 0;
    lock_run("lock_point_gapped", 1'b1, 60);

    // Saturation: isolated errors every other bit never drop lock
    for (int i = 0; i < 540; i++) send(1'b1, (i % 2 == 0), 1'b0);
    check_val("sat_cnt", 32'(bus.err_cnt), 32'd255);
    send(1'b1, 1'b1, 1'b0);
    check_val("sat_hold", 32'(bus.err_cnt), 32'd255);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    check_val("clr_wins_cnt",   32'(bus.err_cnt),   32'd0);
    check_val("clr_wins_pulse", 32'(bus.err_pulse), 32'd1);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-lock, then reacquire from an arbitrary phase
    send(1'b1, 1'b1, 1'b0);
    async_reset(1'b1);
    tx_idx = int'($urandom_range(0, 14));
    lock_run("relock_point", 1'b0, 30);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      int r = int'($urandom_range(0, 999));
      bit en  = ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 59) == 0);
      if (r < 3) tx_idx = int'($urandom_range(0, 14));
      if (r == 999) async_reset(1'b1);
      else if (r >= 960) cycle(en, 1'($urandom), clr);
      else send(en, ($urandom_range(0, 11) == 0), clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
